// File: rtl/receiver.sv
// 8N1 UART receiver: oversamples rx with the system clock, recovers start, WIDTH data
// bits (LSB first) and stop bit, and reports each word with a valid or frame_err strobe.
module receiver #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1736
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             frame_err,
    output logic             busy,
    output logic [3:0]       bit_count
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_C    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_C    = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LASTBIT_C = 4'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
    logic             rxs;

    assign rxs = sync2_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        shift_d  = shift_q;
        data_d   = data_q;
        bitcnt_d = bitcnt_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d  = DATA;
                        bitcnt_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                // New bits enter at the MSB so the first bit received lands in bit 0.
                if (cnt_q == LAST_C) begin
                    cnt_d    = '0;
                    shift_d  = {rxs, shift_q[WIDTH-1:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == LASTBIT_C) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
                if (cnt_q == LAST_C) begin
                    cnt_d = '0;
                    if (rxs) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            bitcnt_q <= 4'd0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= rx;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            bitcnt_q <= bitcnt_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            busy_q   <= busy_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
    assign bit_count = bitcnt_q;
endmodule

// File: doc/receiver.md
# receiver

UART serial receiver: the receive end of the team's 8N1 link, paired with `transmitter`. It oversamples the idle-high `rx` line with the system clock and recovers one start bit, WIDTH data bits (LSB first) and one stop bit. It presents each received word on a parallel bus with a one-cycle `valid` strobe, and flags bad stop bits. It runs on the same 100 MHz clock and baud divisor as `transmitter`, so a `tx`→`rx` loopback exercises both ends.

## Interface
- WIDTH, 8, data bits per frame
- CLKS_PER_BIT, 1736, clock cycles per bit (100 MHz / 57600 baud); legal range ≥ 4

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; one clock domain, no other reset
- rx  in  1  serial line, asynchronous to clk, idle high
- data  out  WIDTH  last correctly framed word; holds until the next good frame
- valid  out  1  one-cycle pulse when `data` updates
- frame_err  out  1  one-cycle pulse when the stop bit samples low
- busy  out  1  high in every state except IDLE
- bit_count  out  4  data bits captured in the current frame, 0..WIDTH

## Operation
- Input synchronizer: 2-flop chain on `rx`; both flops reset to 1. All decisions use the synchronized bit `rxs`.
- Bit-timing counter: width $clog2(CLKS_PER_BIT); zeroed on every state entry.
- State machine: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when `rxs`==0, go to START.
- START: count CLKS_PER_BIT/2 (integer divide) cycles, then sample at mid-bit.
  - `rxs`==0: go to DATA and set bit_count=0.
  - `rxs`==1: treat as a glitch and return to IDLE. No flag is raised.
- DATA: every CLKS_PER_BIT cycles, sample `rxs`.
  - Shift it into a WIDTH-bit shift register at the MSB, shifting right, so the first bit received ends in bit 0.
  - Increment bit_count.
  - When bit_count reaches WIDTH, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample `rxs`.
  - `rxs`==1: copy the shift register to `data`, pulse `valid`, go to IDLE.
  - `rxs`==0: pulse `frame_err`, leave `data` unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rxs`==1, then go to IDLE. A held-low break produces exactly one `frame_err` and no spurious frames.
- bit_count holds WIDTH through STOP and WAIT_IDLE. It clears only on the START→DATA transition or on reset.
- `valid` and `frame_err` are never high in the same cycle.
- Reset at any point, including mid-frame, aborts the frame: FSM to IDLE, no `valid`, no `frame_err`.

## Timing
- Reset values:
  - data = 0, valid = 0, frame_err = 0, busy = 0, bit_count = 0
  - state = IDLE, counter = 0, synchronizer flops = 1
- Synchronizer latency: 2 cycles from an `rx` pin change to `rxs`.
- Let T0 be the first cycle in which IDLE sees `rxs`==0. Measured from T0:
  - Start sample at T0 + 1 + CLKS_PER_BIT/2.
  - Data bit k (k = 0..WIDTH-1) sampled at the start sample + (k+1)·CLKS_PER_BIT.
  - Stop sample at the start sample + (WIDTH+1)·CLKS_PER_BIT.
  - `valid` / `frame_err` registered high in the cycle after the stop sample, for exactly one cycle.
- `busy` rises the cycle after T0. It falls the cycle after leaving STOP (good frame) or WAIT_IDLE.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit immediately following the stop bit is accepted with no lost frame.
- Tolerance: sampling at mid-bit accepts a transmitter baud mismatch up to ±4% at WIDTH=8.
- The receiver has no flow control. A consumer that misses a `valid` pulse loses that word; the next good frame overwrites `data`.

## Test plan
- **Reset state:** assert reset for 5 ns mid-idle. All outputs read 0 and busy=0 during and after reset. Hold `rx`=1 for 1000 cycles → no valid, no frame_err.
- **Single frame (CLKS_PER_BIT=16):** drive 0x99 (start 0, bits 1,0,0,1,1,0,0,1, stop 1).
  - valid pulses once, 1 cycle wide, at the Timing-formula cycle; data=0x99.
  - bit_count steps 0→8; busy falls afterwards.
- **Loopback at defaults:** connect `transmitter` `tx`→`rx`, send 0x99 then 0x70.
  - data=0x99 then 0x70; exactly two valid pulses; frame_err never asserted.
- **Framing error:** drive 0x5A with stop bit 0, then hold `rx` low for 3 bit times.
  - Exactly one frame_err pulse; data keeps its previous value; busy stays high until `rx` returns high.
  - A following good 0xA5 → valid, data=0xA5.
- **Glitch rejection:** a 0 pulse of CLKS_PER_BIT/4 cycles on idle `rx` → busy high briefly, return to IDLE, no valid, no frame_err.
- **Reset mid-frame:** assert reset during data bit 3 of 0xFF.
  - All outputs return to reset values; no valid from the aborted frame.
  - The next full 0x3C frame → data=0x3C.
